flash_bus_bridge: RTL and testbench

- Upstream of the 16-bit flash driver. Converts 32-bit CPU data-bus accesses (byte address, byte selects) into sequences of 16-bit driver commands: read, program and block erase.
- Reads and full-word writes are split into two halfword operations, low half first.
- Returns one single-cycle ack per bus access. A timeout produces an error ack.

---
 rtl/flash_bus_bridge_if.sv | 19 +
 rtl/flash_bus_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_flash_bus_bridge.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_bus_bridge_if.sv
// CPU-side 32-bit data-bus access port of the flash bus bridge.
// The master holds ce with stable fields until it sees ack; err qualifies ack.
interface flash_bus_bridge_if;
   localparam int unsigned ADDR_W = 24;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 4;

   logic              ce;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [SEL_W-1:0]  sel;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              err;

   modport master (output ce, we, addr, sel, wdata, input rdata, ack, err);
   modport slave  (input ce, we, addr, sel, wdata, output rdata, ack, err);
endinterface

// File: rtl/flash_bus_bridge.sv
// Splits 32-bit CPU bus accesses into 16-bit flash driver read/program/erase
// sub-operations, each guarded by a watchdog; one ack (optionally err) per access.
module flash_bus_bridge #(
   parameter int unsigned TIMEOUT_W = 20,
   parameter int unsigned CMD_BIT   = 23
) (
   input  logic                     clk,
   input  logic                     rst,
   flash_bus_bridge_if.slave        bus,
   output logic                     drv_ce_o,
   output logic [21:0]              drv_addr_o,
   output logic [15:0]              drv_data_o,
   input  logic [15:0]              drv_data_i,
   output logic                     drv_read_o,
   output logic                     drv_write_o,
   output logic                     drv_erase_o,
   input  logic                     drv_ack_i
);

   localparam int unsigned HW_W   = 22;
   localparam int unsigned WORD_W = 21;
   localparam int unsigned HALF_W = 16;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RD_LO = 3'd1;
   localparam logic [2:0] RD_HI = 3'd2;
   localparam logic [2:0] WR_LO = 3'd3;
   localparam logic [2:0] WR_HI = 3'd4;
   localparam logic [2:0] ERASE = 3'd5;
   localparam logic [2:0] GAP   = 3'd6;
   localparam logic [2:0] DONE  = 3'd7;

   localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

   logic [2:0]           state_q, state_d;
   logic [2:0]           next_q, next_d;
   logic [WORD_W-1:0]    word_q, word_d;
   logic [HALF_W-1:0]    whi_q, whi_d;
   logic                 full_q, full_d;
   logic                 is_rd_q, is_rd_d;
   logic                 err_q, err_d;
   logic                 armed_q, armed_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;
   logic [31:0]          buf_q, buf_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [HW_W-1:0]      addr_q, addr_d;
   logic [HALF_W-1:0]    data_q, data_d;
   logic                 rd_q, rd_d;
   logic                 wr_q, wr_d;
   logic                 er_q, er_d;
   logic                 ack_q, ack_d;
   logic                 berr_q, berr_d;
   logic                 ce_q;
   logic                 unused_addr_c;

   // Byte lanes within a halfword carry no information for the driver.
   assign unused_addr_c = ^bus.addr[1:0];

   assign drv_ce_o    = ce_q;
   assign drv_addr_o  = addr_q;
   assign drv_data_o  = data_q;
   assign drv_read_o  = rd_q;
   assign drv_write_o = wr_q;
   assign drv_erase_o = er_q;
   assign bus.rdata   = rdata_q;
   assign bus.ack     = ack_q;
   assign bus.err     = berr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         next_q  <= DONE;
         word_q  <= '0;
         whi_q   <= '0;
         full_q  <= 1'b0;
         is_rd_q <= 1'b0;
         err_q   <= 1'b0;
         armed_q <= 1'b0;
         wd_q    <= '0;
         buf_q   <= '0;
         rdata_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         er_q    <= 1'b0;
         ack_q   <= 1'b0;
         berr_q  <= 1'b0;
         ce_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         next_q  <= next_d;
         word_q  <= word_d;
         whi_q   <= whi_d;
         full_q  <= full_d;
         is_rd_q <= is_rd_d;
         err_q   <= err_d;
         armed_q <= armed_d;
         wd_q    <= wd_d;
         buf_q   <= buf_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         er_q    <= er_d;
         ack_q   <= ack_d;
         berr_q  <= berr_d;
         ce_q    <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      next_d  = next_q;
      word_d  = word_q;
      whi_d   = whi_q;
      full_d  = full_q;
      is_rd_d = is_rd_q;
      err_d   = err_q;
      armed_d = armed_q;
      wd_d    = wd_q;
      buf_d   = buf_q;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      er_d    = 1'b0;
      ack_d   = 1'b0;
      berr_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.ce) begin
               word_d  = bus.addr[22:2];
               whi_d   = bus.wdata[31:16];
               is_rd_d = !bus.we;
               full_d  = 1'b0;
               err_d   = 1'b0;
               armed_d = 1'b0;
               wd_d    = '0;
               if (!bus.we) begin
                  state_d = RD_LO;
                  rd_d    = 1'b1;
                  addr_d  = {bus.addr[22:2], 1'b0};
               end else if (bus.addr[CMD_BIT]) begin
                  state_d = ERASE;
                  er_d    = 1'b1;
                  addr_d  = bus.wdata[21:0];
                  data_d  = bus.wdata[15:0];
               end else if (bus.sel == 4'b1111 || bus.sel == 4'b0011) begin
                  state_d = WR_LO;
                  wr_d    = 1'b1;
                  full_d  = bus.sel[3];
                  addr_d  = {bus.addr[22:2], 1'b0};
                  data_d  = bus.wdata[15:0];
               end else if (bus.sel == 4'b1100) begin
                  state_d = WR_HI;
                  wr_d    = 1'b1;
                  addr_d  = {bus.addr[22:2], 1'b1};
                  data_d  = bus.wdata[31:16];
               end else begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  ack_d   = 1'b1;
                  berr_d  = 1'b1;
               end
            end
         end

         RD_LO, RD_HI, WR_LO, WR_HI, ERASE: begin
            rd_d = rd_q;
            wr_d = wr_q;
            er_d = er_q;
            wd_d = wd_q + TIMEOUT_W'(1);
            if (!drv_ack_i) armed_d = 1'b1;
            // Completion needs a low-then-high ack so an idle-high driver is not mistaken for done.
            if (armed_q && drv_ack_i) begin
               state_d = GAP;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               er_d    = 1'b0;
               if (state_q == RD_LO) buf_d[15:0]  = drv_data_i;
               if (state_q == RD_HI) buf_d[31:16] = drv_data_i;
               if (state_q == RD_LO)                  next_d = RD_HI;
               else if (state_q == WR_LO && full_q)   next_d = WR_HI;
               else                                   next_d = DONE;
            end else if (wd_q == WD_MAX) begin
               state_d = GAP;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               er_d    = 1'b0;
               err_d   = 1'b1;
               next_d  = DONE;
            end
         end

         GAP: begin
            state_d = next_q;
            armed_d = 1'b0;
            wd_d    = '0;
            if (next_q == RD_HI) begin
               rd_d   = 1'b1;
               addr_d = {word_q, 1'b1};
            end else if (next_q == WR_HI) begin
               wr_d   = 1'b1;
               addr_d = {word_q, 1'b1};
               data_d = whi_q;
            end else begin
               state_d = DONE;
               ack_d   = 1'b1;
               berr_d  = err_q;
               if (is_rd_q && !err_q) rdata_d = buf_q;
            end
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_flash_bus_bridge.sv
// Directed and randomized bench for flash_bus_bridge with a behavioural flash driver
// model and a bus-level reference memory.
module tb_flash_bus_bridge;
   localparam int unsigned TW = 4;

   typedef struct packed {
      logic [1:0]  k;   // 1 read, 2 program, 3 erase
      logic [21:0] a;
      logic [15:0] d;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        drv_ce_o, drv_read_o, drv_write_o, drv_erase_o;
   logic [21:0] drv_addr_o;
   logic [15:0] drv_data_o;
   logic [15:0] drv_data_i = 16'h0;
   logic        drv_ack_i  = 1'b1;

   flash_bus_bridge_if bus ();

   flash_bus_bridge #(.TIMEOUT_W(TW), .CMD_BIT(23)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .drv_ce_o    (drv_ce_o),
      .drv_addr_o  (drv_addr_o),
      .drv_data_o  (drv_data_o),
      .drv_data_i  (drv_data_i),
      .drv_read_o  (drv_read_o),
      .drv_write_o (drv_write_o),
      .drv_erase_o (drv_erase_o),
      .drv_ack_i   (drv_ack_i)
   );

   always #5 clk = ~clk;

   cmd_t        dm_log[$];
   cmd_t        dm_cur;
   logic [15:0] dm_mem  [logic [21:0]];
   logic [15:0] ref_mem [logic [21:0]];
   logic [2:0]  dm_ens;
   int          dm_phase = 0;
   int          dm_cnt   = 0;
   int          dm_viol  = 0;
   bit          stall    = 1'b0;
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] last_rd  = 32'h0;

   // Flash contents before any program operation.
   function automatic logic [15:0] init_hw(input logic [21:0] a);
      if (a == 22'h8) return 16'h1234;
      if (a == 22'h9) return 16'hABCD;
      return a[15:0] ^ 16'hC3A5 ^ {a[21:16], 10'h0};
   endfunction

   function automatic logic [15:0] dm_rd(input logic [21:0] a);
      return dm_mem.exists(a) ? dm_mem[a] : init_hw(a);
   endfunction

   function automatic logic [15:0] ref_rd(input logic [21:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_hw(a);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Flash driver model: ack idles high, drops after a random delay, then rises with data.
   always @(posedge clk) begin
      #1;
      dm_ens = {drv_erase_o, drv_write_o, drv_read_o};
      if (dm_ens != 3'b000 && $countones(dm_ens) != 1) dm_viol++;
      if ((dm_phase == 1 || dm_phase == 2 || dm_phase == 4) && dm_ens != 3'b000 &&
          (drv_addr_o !== dm_cur.a || (dm_ens[1] && drv_data_o !== dm_cur.d))) dm_viol++;
      case (dm_phase)
         0: if (dm_ens != 3'b000) begin
               dm_cur.k = dm_ens[2] ? 2'd3 : (dm_ens[1] ? 2'd2 : 2'd1);
               dm_cur.a = drv_addr_o;
               dm_cur.d = dm_ens[1] ? drv_data_o : 16'h0;
               dm_log.push_back(dm_cur);
               if (stall) begin
                  drv_ack_i = 1'b0;
                  dm_phase  = 4;
               end else begin
                  dm_cnt   = int'($urandom_range(0, 2));
                  dm_phase = 1;
               end
            end
         1: if (dm_ens == 3'b000) begin drv_ack_i = 1'b1; dm_phase = 0; end
            else if (dm_cnt == 0) begin
               drv_ack_i = 1'b0;
               dm_cnt    = int'($urandom_range(0, 3));
               dm_phase  = 2;
            end else dm_cnt--;
         2: if (dm_ens == 3'b000) begin drv_ack_i = 1'b1; dm_phase = 0; end
            else if (dm_cnt == 0) begin
               if (dm_cur.k == 2'd2) dm_mem[dm_cur.a] = dm_cur.d;
               if (dm_cur.k == 2'd1) drv_data_i = dm_rd(dm_cur.a);
               drv_ack_i = 1'b1;
               dm_phase  = 3;
            end else dm_cnt--;
         3: if (dm_ens == 3'b000) begin
               drv_data_i = 16'($urandom);
               dm_phase   = 0;
            end
         4: if (dm_ens == 3'b000) begin drv_ack_i = 1'b1; dm_phase = 0; end
         default: dm_phase = 0;
      endcase
   end

   task automatic access(input logic we, input logic [23:0] addr, input logic [3:0] sel,
                         input logic [31:0] wd, input bit drop,
                         output logic [31:0] rd, output logic er, output int cyc);
      bit got;
      got       = 1'b0;
      cyc       = 0;
      bus.we    = we;
      bus.addr  = addr;
      bus.sel   = sel;
      bus.wdata = wd;
      bus.ce    = 1'b1;
      while (!got && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.ack) got = 1'b1;
         else if (drop && cyc == 2) begin
            bus.ce    = 1'b0;
            bus.we    = ~we;
            bus.addr  = ~addr;
            bus.sel   = ~sel;
            bus.wdata = ~wd;
         end
      end
      check("ack_seen", 64'(got), 64'd1);
      rd     = bus.rdata;
      er     = bus.err;
      bus.ce = 1'b0;
      @(posedge clk); #1;
      check("ack_single", 64'(bus.ack), 64'd0);
   endtask

   // One bus access, with expected driver commands, error and read data derived from the bus rules.
   task automatic run(input logic we, input logic [23:0] addr, input logic [3:0] sel,
                      input logic [31:0] wd, input bit drop, input string tag);
      cmd_t        exp[$];
      logic        exp_err;
      logic [31:0] exp_rd;
      logic [21:0] lo, hi;
      logic [31:0] rd;
      logic        er;
      int          cyc, st;
      lo      = {addr[22:2], 1'b0};
      hi      = lo + 22'd1;
      exp_err = 1'b0;
      exp_rd  = last_rd;
      if (!we) begin
         exp.push_back('{2'd1, lo, 16'h0});
         exp.push_back('{2'd1, hi, 16'h0});
         exp_rd = {ref_rd(hi), ref_rd(lo)};
      end else if (addr[23]) begin
         exp.push_back('{2'd3, wd[21:0], 16'h0});
      end else if (sel == 4'b1111) begin
         exp.push_back('{2'd2, lo, wd[15:0]});
         exp.push_back('{2'd2, hi, wd[31:16]});
         ref_mem[lo] = wd[15:0];
         ref_mem[hi] = wd[31:16];
      end else if (sel == 4'b0011) begin
         exp.push_back('{2'd2, lo, wd[15:0]});
         ref_mem[lo] = wd[15:0];
      end else if (sel == 4'b1100) begin
         exp.push_back('{2'd2, hi, wd[31:16]});
         ref_mem[hi] = wd[31:16];
      end else begin
         exp_err = 1'b1;
      end
      st = dm_log.size();
      access(we, addr, sel, wd, drop, rd, er, cyc);
      check({tag, "_err"}, 64'(er), 64'(exp_err));
      check({tag, "_ncmd"}, 64'(dm_log.size() - st), 64'(exp.size()));
      foreach (exp[i])
         if (st + i < dm_log.size())
            check($sformatf("%s_cmd%0d", tag, i), 64'(dm_log[st + i]), 64'(exp[i]));
      check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
      last_rd = exp_rd;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          cyc, st, acks;
      logic [23:0] a;
      logic [3:0]  s;
      int          r;

      bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.sel = '0; bus.wdata = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack_err", 64'({bus.ack, bus.err}), 64'd0);
      check("rst_rdata", 64'(bus.rdata), 64'd0);
      check("rst_drv_ctl", 64'({drv_ce_o, drv_read_o, drv_write_o, drv_erase_o}), 64'b1000);
      check("rst_drv_bus", 64'({drv_addr_o, drv_data_o}), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run(1'b0, 24'h000010, 4'hF, 32'h0, 1'b0, "rd10");
      check("rd10_value", 64'(last_rd), 64'hABCD1234);
      run(1'b1, 24'h000020, 4'hF, 32'hDEADBEEF, 1'b0, "wr20");
      run(1'b1, 24'h000004, 4'hC, 32'h55660000, 1'b0, "wr04hi");
      run(1'b1, 24'h800000, 4'hF, 32'h00010000, 1'b0, "erase");
      run(1'b1, 24'h000008, 4'h3, 32'h0000A5A5, 1'b0, "wr08lo");
      run(1'b1, 24'h00000C, 4'h1, 32'h11111111, 1'b0, "badsel");
      run(1'b0, 24'h000020, 4'h0, 32'h0, 1'b0, "rd20");
      run(1'b0, 24'h000004, 4'hF, 32'h0, 1'b0, "rd04");
      run(1'b1, 24'h7FFFFC, 4'hF, 32'h13572468, 1'b0, "wrwrap");
      run(1'b0, 24'h7FFFFE, 4'hF, 32'h0, 1'b0, "rdwrap");
      run(1'b1, 24'h000030, 4'hF, 32'hCAFEF00D, 1'b1, "wrdrop");
      run(1'b0, 24'h000030, 4'hF, 32'h0, 1'b1, "rddrop");

      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         a = {1'b0, ($urandom_range(0, 1) != 0) ? 23'($urandom_range(0, 63))
                                               : 23'h7FFFC0 + 23'($urandom_range(0, 63))};
         case ($urandom_range(0, 2))
            0:       s = 4'hF;
            1:       s = 4'h3;
            default: s = 4'hC;
         endcase
         if (r < 4) begin
            a[23] = 1'($urandom_range(0, 1));
            run(1'b0, a, 4'($urandom), 32'($urandom), ($urandom_range(0, 4) == 0), $sformatf("rnd%0d_rd", i));
         end else begin
            if (r == 9) begin
               s = 4'($urandom_range(0, 15));
               if (s == 4'hF || s == 4'h3 || s == 4'hC) s = 4'h5;
            end
            run(1'b1, a, s, 32'($urandom), ($urandom_range(0, 4) == 0), $sformatf("rnd%0d_wr", i));
         end
      end

      // Driver never answers: watchdog must end the access with an error.
      stall = 1'b1;
      st = dm_log.size();
      access(1'b0, 24'h000040, 4'hF, 32'h0, 1'b0, rd, er, cyc);
      stall = 1'b0;
      check("to_err", 64'(er), 64'd1);
      check("to_latency", 64'(cyc >= 16 && cyc <= 20), 64'd1);
      check("to_ncmd", 64'(dm_log.size() - st), 64'd1);
      check("to_enables", 64'({drv_read_o, drv_write_o, drv_erase_o}), 64'd0);
      check("to_rdata_held", 64'(rd), 64'(last_rd));
      run(1'b0, 24'h000040, 4'hF, 32'h0, 1'b0, "after_to");

      // Reset while the high-half read is on the driver.
      st = dm_log.size();
      bus.we = 1'b0; bus.addr = 24'h000050; bus.sel = 4'hF; bus.wdata = '0; bus.ce = 1'b1;
      cyc = 0;
      while (dm_log.size() - st < 2 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("rst_reach_hi", 64'(dm_log.size() - st), 64'd2);
      check("rst_hi_read_on", 64'(drv_read_o), 64'd1);
      rst = 1'b1;
      bus.ce = 1'b0;
      @(posedge clk); #1;
      check("rstmid_enables", 64'({drv_read_o, drv_write_o, drv_erase_o}), 64'd0);
      check("rstmid_ack", 64'(bus.ack), 64'd0);
      rst = 1'b0;
      acks = 0;
      repeat (4) begin
         @(posedge clk); #1;
         acks += int'(bus.ack);
      end
      check("rstmid_no_ack", 64'(acks), 64'd0);
      check("rstmid_rdata", 64'(bus.rdata), 64'd0);
      last_rd = 32'h0;
      run(1'b0, 24'h000050, 4'hF, 32'h0, 1'b0, "after_rst");
      run(1'b0, 24'h000010, 4'hF, 32'h0, 1'b0, "rd10_again");

      check("drv_protocol", 64'(dm_viol), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
